// File: rtl/bomb_scheduler_pkg.sv
// Shared invader constants: sprite/step geometry, bomb scheduler defaults and FSM encoding.
package bomb_scheduler_pkg;

  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 8;
  localparam int STEP_PX  = 2;

  localparam int NUM_SLOTS_DEF     = 3;
  localparam int NUM_COLS_DEF      = 6;
  localparam int FIRE_INTERVAL_DEF = 32;
  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Slot and column indices are carried as 3 bits regardless of parameter values.
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    ST_COOLDOWN = 2'd0,
    ST_SELECT   = 2'd1,
    ST_LAUNCH   = 2'd2
  } bs_state_e;

endpackage

// File: rtl/bomb_scheduler_if.sv
// Bomb scheduler bus: game-side inputs and launch/occupancy outputs.
interface bomb_scheduler_if import bomb_scheduler_pkg::*; #(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int NUM_COLS  = NUM_COLS_DEF
);
  logic                 frame;
  logic                 done;
  logic [NUM_COLS-1:0]  col_alive;
  logic [NUM_SLOTS-1:0] bomb_release;
  logic                 launch;
  logic [IDX_W-1:0]     launch_slot;
  logic [IDX_W-1:0]     launch_col;
  logic [NUM_SLOTS-1:0] slot_busy;

  modport master (
    output frame, done, col_alive, bomb_release,
    input  launch, launch_slot, launch_col, slot_busy
  );

  modport slave (
    input  frame, done, col_alive, bomb_release,
    output launch, launch_slot, launch_col, slot_busy
  );
endinterface

// File: rtl/bomb_scheduler_rr_col_select.sv
// rr_col_select: first set bit of i_req scanning circularly from i_start; purely combinational.
module rr_col_select import bomb_scheduler_pkg::*; #(
  parameter int NUM_COLS = NUM_COLS_DEF
) (
  input  logic [NUM_COLS-1:0] i_req,
  input  logic [IDX_W-1:0]    i_start,
  output logic [IDX_W-1:0]    o_grant,
  output logic                o_grant_vld
);
  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0]    w_idx;
  logic [NUM_COLS-1:0] w_shift;

  // Walk offsets from the far end so the smallest offset from i_start wins.
  always_comb begin
    o_grant     = '0;
    o_grant_vld = 1'b0;
    w_idx       = '0;
    w_shift     = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--) begin
      w_idx = {1'b0, i_start} + SUM_W'(i);
      if (w_idx >= SUM_W'(NUM_COLS)) w_idx = w_idx - SUM_W'(NUM_COLS);
      w_shift = i_req >> w_idx;
      if (w_shift[0]) begin
        o_grant     = w_idx[IDX_W-1:0];
        o_grant_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bomb_scheduler.sv
// Invader bomb scheduler: launch 2 cycles after the qualifying frame; stalls in SELECT without a free slot/live column.
// Optional BOMB_SCHEDULER_LFSR_EN adds an 8-bit LFSR offset to the round-robin column scan start.
module bomb_scheduler import bomb_scheduler_pkg::*; #(
  parameter int NUM_SLOTS     = NUM_SLOTS_DEF,
  parameter int NUM_COLS      = NUM_COLS_DEF,
  parameter int FIRE_INTERVAL = FIRE_INTERVAL_DEF
) (
  input logic             clk,
  input logic             rst,
  bomb_scheduler_if.slave bus
);
  localparam int               CNT_W      = $clog2(FIRE_INTERVAL + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FIRE_INTERVAL - 1);
  localparam logic [IDX_W-1:0] RR_INIT    = IDX_W'(NUM_COLS - 1);

  bs_state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]     r_rr, w_rr_nxt;
  logic [IDX_W-1:0]     r_slot, w_slot_nxt;
  logic [IDX_W-1:0]     r_col, w_col_nxt;
  logic [NUM_SLOTS-1:0] r_busy, w_busy_nxt;
  logic                 r_launch, w_launch_nxt;

  logic                 w_clr;
  logic [IDX_W-1:0]     w_start;
  logic [IDX_W-1:0]     w_free_slot;
  logic                 w_free_vld;
  logic [IDX_W-1:0]     w_grant;
  logic                 w_grant_vld;

  assign w_clr = rst | bus.done;

`ifdef BOMB_SCHEDULER_LFSR_EN
  logic [7:0]       r_lfsr;
  logic [IDX_W:0]   w_start_sum;

  always_ff @(posedge clk) begin
    if (w_clr)          r_lfsr <= LFSR_SEED;
    else if (bus.frame) r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  assign w_start_sum = {1'b0, r_rr} + (IDX_W+1)'(1) + {1'b0, r_lfsr[2:0]};
  assign w_start     = IDX_W'(w_start_sum % (IDX_W+1)'(NUM_COLS));
`else
  assign w_start = (r_rr >= RR_INIT) ? '0 : r_rr + IDX_W'(1);
`endif

  always_comb begin
    w_free_slot = '0;
    w_free_vld  = 1'b0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (!r_busy[s]) begin
        w_free_slot = IDX_W'(s);
        w_free_vld  = 1'b1;
      end
    end
  end

  rr_col_select #(.NUM_COLS(NUM_COLS)) u_col_sel (
    .i_req       (bus.col_alive),
    .i_start     (w_start),
    .o_grant     (w_grant),
    .o_grant_vld (w_grant_vld)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rr_nxt     = r_rr;
    w_slot_nxt   = r_slot;
    w_col_nxt    = r_col;
    w_launch_nxt = 1'b0;
    // Releases apply in every state; a release on an idle slot is a no-op.
    w_busy_nxt   = r_busy & ~bus.bomb_release;
    case (r_state)
      ST_COOLDOWN: begin
        if (bus.frame) begin
          if (r_cnt == '0) w_state_nxt = ST_SELECT;
          else             w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      ST_SELECT: begin
        if (w_free_vld && w_grant_vld) begin
          w_state_nxt  = ST_LAUNCH;
          w_launch_nxt = 1'b1;
          w_slot_nxt   = w_free_slot;
          w_col_nxt    = w_grant;
        end
      end
      ST_LAUNCH: begin
        w_state_nxt = ST_COOLDOWN;
        w_busy_nxt  = w_busy_nxt | (NUM_SLOTS'(1) << r_slot);
        w_rr_nxt    = r_col;
        w_cnt_nxt   = CNT_RELOAD;
      end
      default: w_state_nxt = ST_COOLDOWN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state  <= ST_COOLDOWN;
      r_cnt    <= CNT_RELOAD;
      r_rr     <= RR_INIT;
      r_slot   <= '0;
      r_col    <= '0;
      r_busy   <= '0;
      r_launch <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rr     <= w_rr_nxt;
      r_slot   <= w_slot_nxt;
      r_col    <= w_col_nxt;
      r_busy   <= w_busy_nxt;
      r_launch <= w_launch_nxt;
    end
  end

  // A clear arriving while in LAUNCH suppresses the pulse already on the wire.
  assign bus.launch      = r_launch & ~w_clr;
  assign bus.launch_slot = r_slot;
  assign bus.launch_col  = r_col;
  assign bus.slot_busy   = r_busy;
endmodule

// File: tb/tb_bomb_scheduler.sv
// Bench for bomb_scheduler: scenario tables, clear/stall corner sequences and a randomized model comparison.
module tb_bomb_scheduler;
  localparam int NS = 3;
  localparam int NC = 6;
  localparam int FI = 4;

  typedef struct {
    int            reps;
    logic          frame;
    logic [NC-1:0] alive;
    logic [NS-1:0] rel;
    logic          exp_launch;
    logic [2:0]    exp_slot;
    logic [2:0]    exp_col;
    logic [NS-1:0] exp_busy;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  vec_t tbl[$];

  // Reference model state: frames still needed before eligibility, hunting flag, launch in flight.
  logic [NS-1:0] m_busy;
  int            m_rr;
  int            m_frames;
  bit            m_wait;
  bit            m_fire;
  int            m_fslot;
  int            m_fcol;

  bomb_scheduler_if #(.NUM_SLOTS(NS), .NUM_COLS(NC)) bus ();

  bomb_scheduler #(.NUM_SLOTS(NS), .NUM_COLS(NC), .FIRE_INTERVAL(FI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input int reps, input logic fr, input logic [NC-1:0] al, input logic [NS-1:0] rl,
                     input logic el, input int es, input int ec, input logic [NS-1:0] eb);
    vec_t v;
    v.reps = reps; v.frame = fr; v.alive = al; v.rel = rl;
    v.exp_launch = el; v.exp_slot = 3'(es); v.exp_col = 3'(ec); v.exp_busy = eb;
    tbl.push_back(v);
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        bus.frame        = tbl[i].frame;
        bus.col_alive    = tbl[i].alive;
        bus.bomb_release = tbl[i].rel;
        tick();
        chk($sformatf("%s[%0d] launch", tag, i), 32'(bus.launch), 32'(tbl[i].exp_launch));
        if (tbl[i].exp_launch) begin
          chk($sformatf("%s[%0d] slot", tag, i), 32'(bus.launch_slot), 32'(tbl[i].exp_slot));
          chk($sformatf("%s[%0d] col", tag, i), 32'(bus.launch_col), 32'(tbl[i].exp_col));
        end
        chk($sformatf("%s[%0d] busy", tag, i), 32'(bus.slot_busy), 32'(tbl[i].exp_busy));
      end
    end
    tbl.delete();
    bus.frame        = 1'b0;
    bus.bomb_release = '0;
  endtask

  task automatic do_reset(input string tag);
    rst              = 1'b1;
    bus.done         = 1'b0;
    bus.frame        = 1'b0;
    bus.bomb_release = '0;
    tick();
    chk({tag, " rst launch"}, 32'(bus.launch), 32'd0);
    chk({tag, " rst slot"}, 32'(bus.launch_slot), 32'd0);
    chk({tag, " rst col"}, 32'(bus.launch_col), 32'd0);
    chk({tag, " rst busy"}, 32'(bus.slot_busy), 32'd0);
    rst = 1'b0;
  endtask

  task automatic model_step(input bit fr, input bit dn, input logic [NC-1:0] al, input logic [NS-1:0] rl);
    logic [NS-1:0] nb;
    bit            fire_next;
    int            slot, col;
    if (dn) begin
      m_busy = '0; m_rr = NC - 1; m_frames = FI; m_wait = 0; m_fire = 0;
      return;
    end
    nb        = m_busy & ~rl;
    fire_next = 0;
    if (m_fire) begin
      nb[m_fslot] = 1'b1;
      m_rr        = m_fcol;
      m_frames    = FI;
    end else if (m_wait) begin
      slot = -1;
      for (int s = NS - 1; s >= 0; s--) if (!m_busy[s]) slot = s;
      col = -1;
      for (int k = NC; k >= 1; k--) if (al[(m_rr + k) % NC]) col = (m_rr + k) % NC;
      if (slot >= 0 && col >= 0) begin
        fire_next = 1; m_fslot = slot; m_fcol = col; m_wait = 0;
      end
    end else if (fr) begin
      m_frames--;
      if (m_frames == 0) m_wait = 1;
    end
    m_busy = nb;
    m_fire = fire_next;
  endtask

  initial begin
    logic [NC-1:0] al;
    logic [NS-1:0] rl;
    bit            fr, dn;
    int            n_launch, edges;

    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.frame = 1'b0; bus.done = 1'b0; bus.col_alive = '0; bus.bomb_release = '0;
    tick();

    // All columns alive: cols 0,1,2 in slots 0,1,2; slot 0 freed during the third launch.
    do_reset("sc1");
    add(3, 0, 6'h3F, 3'b000, 0, 0, 0, 3'b000);
    add(4, 1, 6'h3F, 3'b000, 0, 0, 0, 3'b000);
    add(1, 1, 6'h3F, 3'b000, 1, 0, 0, 3'b000);
    add(1, 1, 6'h3F, 3'b000, 0, 0, 0, 3'b001);
    add(4, 1, 6'h3F, 3'b000, 0, 0, 0, 3'b001);
    add(1, 1, 6'h3F, 3'b000, 1, 1, 1, 3'b001);
    add(1, 1, 6'h3F, 3'b000, 0, 0, 0, 3'b011);
    add(4, 1, 6'h3F, 3'b000, 0, 0, 0, 3'b011);
    add(1, 1, 6'h3F, 3'b000, 1, 2, 2, 3'b011);
    add(1, 1, 6'h3F, 3'b001, 0, 0, 0, 3'b110);
    add(4, 1, 6'h3F, 3'b000, 0, 0, 0, 3'b110);
    add(1, 1, 6'h3F, 3'b000, 1, 0, 3, 3'b110);
    add(1, 1, 6'h3F, 3'b000, 0, 0, 0, 3'b111);
    run_table("sc1");

    // Columns 2 and 5 alive: 2,5,2 then stall with all slots busy, then release slot 1.
    do_reset("sc2");
    add(4,  1, 6'b100100, 3'b000, 0, 0, 0, 3'b000);
    add(1,  1, 6'b100100, 3'b000, 1, 0, 2, 3'b000);
    add(1,  1, 6'b100100, 3'b000, 0, 0, 0, 3'b001);
    add(4,  1, 6'b100100, 3'b000, 0, 0, 0, 3'b001);
    add(1,  1, 6'b100100, 3'b000, 1, 1, 5, 3'b001);
    add(1,  1, 6'b100100, 3'b000, 0, 0, 0, 3'b011);
    add(4,  1, 6'b100100, 3'b000, 0, 0, 0, 3'b011);
    add(1,  1, 6'b100100, 3'b000, 1, 2, 2, 3'b011);
    add(1,  1, 6'b100100, 3'b000, 0, 0, 0, 3'b111);
    add(40, 1, 6'b100100, 3'b000, 0, 0, 0, 3'b111);
    add(1,  0, 6'b100100, 3'b010, 0, 0, 0, 3'b101);
    add(1,  0, 6'b100100, 3'b000, 1, 1, 5, 3'b101);
    add(1,  0, 6'b100100, 3'b000, 0, 0, 0, 3'b111);
    run_table("sc3");

    // done while the launch pulse is on the wire.
    do_reset("sc5");
    bus.col_alive = 6'h3F;
    bus.frame     = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("sc5 launch before done", 32'(bus.launch), 32'd1);
    bus.frame = 1'b0;
    bus.done  = 1'b1;
    #1;
    chk("sc5 launch masked", 32'(bus.launch), 32'd0);
    tick();
    chk("sc5 busy cleared", 32'(bus.slot_busy), 32'd0);
    chk("sc5 launch after", 32'(bus.launch), 32'd0);
    chk("sc5 slot cleared", 32'(bus.launch_slot), 32'd0);
    chk("sc5 col cleared", 32'(bus.launch_col), 32'd0);
    bus.done  = 1'b0;
    bus.frame = 1'b1;
    edges = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.launch === 1'b1) begin
        edges = i;
        break;
      end
    end
    chk("sc5 reload interval", 32'(edges), 32'd5);
    chk("sc5 relaunch col", 32'(bus.launch_col), 32'd0);

    // No live columns for 100 frames, then a single column appears.
    do_reset("sc6");
    bus.col_alive = '0;
    bus.frame     = 1'b1;
    n_launch      = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.launch === 1'b1) n_launch++;
    end
    chk("sc6 no launch", 32'(n_launch), 32'd0);
    bus.frame     = 1'b0;
    bus.col_alive = 6'b000001;
    edges = -1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      if (bus.launch === 1'b1) begin
        edges = i;
        break;
      end
    end
    chk("sc6 launch seen", 32'(edges > 0), 32'd1);
    chk("sc6 col", 32'(bus.launch_col), 32'd0);
    chk("sc6 slot", 32'(bus.launch_slot), 32'd0);

    // Randomized traffic against the reference model.
    al = 6'h3F;
    for (int n = 0; n < 3000; n++) begin
      fr = ($urandom_range(0, 1) == 1);
      dn = (n == 0) || ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) al = ($urandom_range(0, 3) == 0) ? '0 : NC'($urandom);
      for (int s = 0; s < NS; s++) rl[s] = ($urandom_range(0, 7) == 0);
      bus.frame = fr; bus.done = dn; bus.col_alive = al; bus.bomb_release = rl;
      model_step(fr, dn, al, rl);
      tick();
      chk($sformatf("rnd[%0d] launch", n), 32'(bus.launch), 32'(m_fire));
      if (m_fire) begin
        chk($sformatf("rnd[%0d] slot", n), 32'(bus.launch_slot), 32'(m_fslot));
        chk($sformatf("rnd[%0d] col", n), 32'(bus.launch_col), 32'(m_fcol));
      end
      chk($sformatf("rnd[%0d] busy", n), 32'(bus.slot_busy), 32'(m_busy));
    end
    bus.done = 1'b0; bus.frame = 1'b0; bus.bomb_release = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
